// File: rtl/sample_packer_pkg.sv
// Shared constants, widths and state encoding for the sample packer gearbox.
package sample_packer_pkg;

  localparam logic [23:0] ORDER_LSB = "LSB";
  localparam logic [23:0] ORDER_MSB = "MSB";

  localparam int MAX_OUT_BIT_NUM = 256;
  // Wide enough for the largest fill count (out + in - 1) at the maximum word width.
  localparam int CNT_W = $clog2(2 * MAX_OUT_BIT_NUM) + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic int acc_width(input int out_bits, input int in_bits);
    return out_bits + in_bits - 1;
  endfunction

endpackage

// File: rtl/sample_packer.sv
// Packs C_IN_BIT_NUM-bit samples into a dense stream of C_OUT_BIT_NUM-bit words.
// Optional end-of-frame flush (i_last/o_last, FLUSH state) under SAMPLE_PACKER_LAST_EN.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int          C_IN_BIT_NUM  = 10,
  parameter int          C_OUT_BIT_NUM = 32,
  parameter logic [23:0] C_BIT_ORDER   = "LSB"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [C_IN_BIT_NUM-1:0]  i0,
  input  logic                     i_valid,
  output logic                     o_ready,
`ifdef SAMPLE_PACKER_LAST_EN
  input  logic                     i_last,
  output logic                     o_last,
`endif
  output logic [C_OUT_BIT_NUM-1:0] o0,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid source holds its data until then. o_ready depends combinationally on i_ready.

  localparam int              ACC_W     = acc_width(C_OUT_BIT_NUM, C_IN_BIT_NUM);
  localparam logic [CNT_W-1:0] OUT_N    = CNT_W'(C_OUT_BIT_NUM);
  localparam logic [CNT_W-1:0] IN_N     = CNT_W'(C_IN_BIT_NUM);
  localparam bit              MSB_FIRST = (C_BIT_ORDER == ORDER_MSB);

  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_shift;
  logic [ACC_W-1:0]         acc_ins;
  logic [ACC_W-1:0]         acc_next;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_shift;
  logic [CNT_W-1:0]         cnt_next;
  logic [C_OUT_BIT_NUM-1:0] word;
  logic                     slot_free;
  logic                     full;
  logic                     residue;
  logic                     move;
  logic                     accept;
`ifdef SAMPLE_PACKER_LAST_EN
  logic                     last_word;
`endif

  assign dbg_state = state;

  always_comb begin
    slot_free = !o_valid || i_ready;
    full      = (cnt >= OUT_N);
`ifdef SAMPLE_PACKER_LAST_EN
    residue   = (state == ST_FLUSH) && !full && (cnt != '0);
`else
    residue   = 1'b0;
`endif
    move      = slot_free && (full || residue);
    o_ready   = (!full || move) && (state == ST_RUN) && rst_n;
    accept    = i_valid && o_ready;

    // Unused accumulator bits are kept zero, so the residue word comes out zero-padded.
    word = MSB_FIRST ? acc[ACC_W-1 -: C_OUT_BIT_NUM] : acc[C_OUT_BIT_NUM-1:0];

    acc_shift = acc;
    cnt_shift = cnt;
    if (move) begin
      if (residue) begin
        acc_shift = '0;
        cnt_shift = '0;
      end else begin
        acc_shift = MSB_FIRST ? (acc << C_OUT_BIT_NUM) : (acc >> C_OUT_BIT_NUM);
        cnt_shift = cnt - OUT_N;
      end
    end

    acc_ins  = MSB_FIRST ? ((ACC_W'(i0) << (ACC_W - C_IN_BIT_NUM)) >> cnt_shift)
                         : (ACC_W'(i0) << cnt_shift);
    acc_next = accept ? (acc_shift | acc_ins) : acc_shift;
    cnt_next = accept ? (cnt_shift + IN_N) : cnt_shift;
`ifdef SAMPLE_PACKER_LAST_EN
    last_word = (state == ST_FLUSH) && (cnt_shift == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      acc     <= '0;
      cnt     <= '0;
      o0      <= '0;
      o_valid <= 1'b0;
`ifdef SAMPLE_PACKER_LAST_EN
      o_last  <= 1'b0;
`endif
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (move) begin
        o0      <= word;
        o_valid <= 1'b1;
`ifdef SAMPLE_PACKER_LAST_EN
        o_last  <= last_word;
`endif
      end else if (i_ready) begin
        o_valid <= 1'b0;
`ifdef SAMPLE_PACKER_LAST_EN
        o_last  <= 1'b0;
`endif
      end
`ifdef SAMPLE_PACKER_LAST_EN
      case (state)
        ST_RUN:   if (accept && i_last) state <= ST_FLUSH;
        ST_FLUSH: if (move && last_word) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Directed plus randomized bench for sample_packer; a bit-queue model predicts every word.
`timescale 1ns/1ps
module tb_sample_packer;
  import sample_packer_pkg::*;

  localparam int IN_W  = 10;
  localparam int OUT_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IN_W-1:0]  i0 = '0;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic             i_last = 1'b0;
  logic [OUT_W-1:0] o0;
  logic             o_valid, o_ready, o_last_obs, dbg_state;

  logic [7:0]       i0_8 = '0;
  logic             v8 = 1'b0;
  logic [31:0]      o0_m, o0_l;
  logic             ov_m, ov_l, or_m, or_l, ds_m, ds_l;

`ifdef SAMPLE_PACKER_LAST_EN
  logic ol_m, ol_l;
`else
  assign o_last_obs = 1'b0;
`endif

  sample_packer #(.C_IN_BIT_NUM(IN_W), .C_OUT_BIT_NUM(OUT_W), .C_BIT_ORDER("LSB")) dut (
    .clk(clk), .rst_n(rst_n), .i0(i0), .i_valid(i_valid), .o_ready(o_ready),
`ifdef SAMPLE_PACKER_LAST_EN
    .i_last(i_last), .o_last(o_last_obs),
`endif
    .o0(o0), .o_valid(o_valid), .i_ready(i_ready), .dbg_state(dbg_state)
  );

  sample_packer #(.C_IN_BIT_NUM(8), .C_OUT_BIT_NUM(32), .C_BIT_ORDER("MSB")) dut_msb8 (
    .clk(clk), .rst_n(rst_n), .i0(i0_8), .i_valid(v8), .o_ready(or_m),
`ifdef SAMPLE_PACKER_LAST_EN
    .i_last(1'b0), .o_last(ol_m),
`endif
    .o0(o0_m), .o_valid(ov_m), .i_ready(1'b1), .dbg_state(ds_m)
  );

  sample_packer #(.C_IN_BIT_NUM(8), .C_OUT_BIT_NUM(32), .C_BIT_ORDER("LSB")) dut_lsb8 (
    .clk(clk), .rst_n(rst_n), .i0(i0_8), .i_valid(v8), .o_ready(or_l),
`ifdef SAMPLE_PACKER_LAST_EN
    .i_last(1'b0), .o_last(ol_l),
`endif
    .o0(o0_l), .o_valid(ov_l), .i_ready(1'b1), .dbg_state(ds_l)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_words = 0;
  int stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: the packed stream is a plain bit queue, first bit = word bit 0
  logic        bitq[$];
  logic [32:0] exp_q[$];

  task automatic model_accept(input logic [IN_W-1:0] s, input logic last);
    logic [31:0] w;
    logic [32:0] tail;
    for (int b = 0; b < IN_W; b++) bitq.push_back(s[b]);
    while (bitq.size() >= OUT_W) begin
      for (int k = 0; k < OUT_W; k++) w[k] = bitq.pop_front();
      exp_q.push_back({1'b0, w});
    end
    if (last) begin
`ifdef SAMPLE_PACKER_LAST_EN
      if (bitq.size() > 0) begin
        w = '0;
        for (int k = 0; bitq.size() > 0; k++) w[k] = bitq.pop_front();
        exp_q.push_back({1'b1, w});
      end else begin
        tail = exp_q.pop_back();
        tail[32] = 1'b1;
        exp_q.push_back(tail);
      end
`endif
    end
  endtask

  // scoreboard: words are compared when consumed, samples enter the model when accepted
  always @(negedge clk) begin
    if (!rst_n) begin
      bitq.delete();
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        n_words++;
        if (exp_q.size() == 0)
          check("word_unexpected", {31'b0, o_last_obs, o0}, 64'h8000_0000_0000_0000);
        else
          check("word", {31'b0, o_last_obs, o0}, {31'b0, exp_q.pop_front()});
      end
      if (i_valid && o_ready) begin
        n_acc++;
        model_accept(i0, i_last);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    v8      = 1'b0;
    i_last  = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o0", 64'(o0), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd0);
    check("rst_o_last", 64'(o_last_obs), 64'd0);
    check("rst_msb_o_ready", 64'(or_m), 64'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_o_ready", 64'(o_ready), 64'd1);
    check("post_rst_state", 64'(dbg_state), 64'(ST_RUN));
    check("post_rst_lsb8_ready", 64'(or_l), 64'd1);
    tick();
  endtask

  task automatic send(input logic [IN_W-1:0] s, input logic last);
    i0      = s;
    i_valid = 1'b1;
    i_last  = last;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (o_ready) break;
      stall_cnt++;
    end
    if (!o_ready) check("send_timeout", 64'(o_ready), 64'd1);
    tick();
    i_last = 1'b0;
  endtask

  logic [31:0] snap;
  bit          have_snap;
  int          base;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic 10->32 LSB packing and residue carry-over
    do_reset();
    i_ready = 1'b1;
    send(10'h3FF, 1'b0);
    send(10'h001, 1'b0);
    send(10'h2AA, 1'b0);
    send(10'h155, 1'b0);
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("basic_valid", 64'(o_valid), 64'd1);
    check("basic_word", 64'(o0), 64'h6AA007FF);
    tick();
    // eight residue bits 0x55 followed by 30 zero bits form the next word
    send(10'h000, 1'b0);
    send(10'h000, 1'b0);
    send(10'h000, 1'b0);
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("residue_word", 64'(o0), 64'h00000055);
    tick();

`ifdef SAMPLE_PACKER_LAST_EN
    // end-of-frame flush with zero-padded residue
    do_reset();
    send(10'h3FF, 1'b0);
    send(10'h001, 1'b0);
    send(10'h2AA, 1'b0);
    send(10'h155, 1'b1);
    i_valid = 1'b0;
    @(negedge clk);
    check("flush_blocks_input", 64'(o_ready), 64'd0);
    tick();
    @(negedge clk);
    check("flush_word1", 64'(o0), 64'h6AA007FF);
    check("flush_word1_last", 64'(o_last_obs), 64'd0);
    check("flush_still_blocked", 64'(o_ready), 64'd0);
    tick();
    @(negedge clk);
    check("flush_word2", 64'(o0), 64'h00000055);
    check("flush_word2_last", 64'(o_last_obs), 64'd1);
    check("flush_back_to_run", 64'(o_ready), 64'd1);
    tick();
`endif

    // sustained throughput: 160 bits make exactly five all-ones words
    do_reset();
    i_ready   = 1'b1;
    stall_cnt = 0;
    base      = n_words;
    for (int n = 0; n < 16; n++) send(10'h3FF, 1'b0);
    i_valid = 1'b0;
    repeat (4) tick();
    check("thru_no_stall", 64'(stall_cnt), 64'd0);
    check("thru_words", 64'(n_words - base), 64'd5);
    check("thru_last_word", 64'(o0), 64'hFFFFFFFF);
    check("thru_queue_empty", 64'(exp_q.size()), 64'd0);

    // back-pressure: one word held at the output plus up to 38 bits in acc = 7 samples
    do_reset();
    i_ready   = 1'b0;
    i_valid   = 1'b1;
    base      = n_acc;
    have_snap = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i0 = 10'($urandom_range(0, 1023));
      @(negedge clk);
      if (o_valid) begin
        if (!have_snap) begin
          snap      = o0;
          have_snap = 1'b1;
        end else begin
          check("bp_o0_stable", 64'(o0), 64'(snap));
        end
      end
      tick();
    end
    @(negedge clk);
    check("bp_o_ready_low", 64'(o_ready), 64'd0);
    check("bp_accepts", 64'(n_acc - base), 64'd7);
    tick();
    i_valid = 1'b0;
    i_ready = 1'b1;
    base    = n_words;
    repeat (6) tick();
    check("bp_drained_words", 64'(n_words - base), 64'd2);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // 8->32 byte ordering in both bit orders
    do_reset();
    v8   = 1'b1;
    i0_8 = 8'h11; tick();
    i0_8 = 8'h22; tick();
    i0_8 = 8'h33; tick();
    i0_8 = 8'h44; tick();
    v8 = 1'b0;
    tick();
    @(negedge clk);
    check("msb8_valid", 64'(ov_m), 64'd1);
    check("msb8_word", 64'(o0_m), 64'h11223344);
    check("lsb8_valid", 64'(ov_l), 64'd1);
    check("lsb8_word", 64'(o0_l), 64'h44332211);
    check("msb8_state", 64'(ds_m), 64'(ST_RUN));
    tick();

    // reset mid-frame (cnt=20) discards the partial word
    do_reset();
    i_ready = 1'b1;
    send(10'h0AB, 1'b0);
    send(10'h0CD, 1'b0);
    i_valid = 1'b0;
    tick();
    base = n_words;
    do_reset();
    check("midrst_no_word", 64'(n_words - base), 64'd0);
    send(10'h3FF, 1'b0);
    send(10'h001, 1'b0);
    send(10'h2AA, 1'b0);
    send(10'h155, 1'b0);
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_replay_word", 64'(o0), 64'h6AA007FF);
    tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i0      = 10'($urandom_range(0, 1023));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 9) < 7);
      i_last  = ($urandom_range(0, 19) == 0);
      tick();
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (30) tick();
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_idle_valid", 64'(o_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
# sample_packer

Streaming gearbox that packs consecutive C_IN_BIT_NUM-bit samples, as produced by the bit-width extend stage, into a dense bitstream of C_OUT_BIT_NUM-bit words with no padding between samples. It sits directly downstream of the extend stage and feeds word-oriented sinks such as FIFOs, DMA and AXI-Stream bridges. It uses valid/ready handshakes on both sides and an optional end-of-frame flush.

## Interface
- C_IN_BIT_NUM, 10, sample width; 1 ≤ C_IN_BIT_NUM ≤ C_OUT_BIT_NUM.
- C_OUT_BIT_NUM, 32, output word width; ≤ 256.
- C_BIT_ORDER, "LSB", "LSB": first sample occupies word bit 0 upward. "MSB": first sample occupies the top bits.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i0  in  C_IN_BIT_NUM  input sample.
- i_valid  in  1  sample valid.
- o_ready  out  1  sample accepted when i_valid && o_ready.
- i_last  in  1  last sample of frame; present only with the flush macro.
- o0  out  C_OUT_BIT_NUM  packed word.
- o_valid  out  1  word valid.
- i_ready  in  1  word consumed when o_valid && i_ready.
- o_last  out  1  final word of frame; present only with the flush macro.

## Operation
- Accumulator acc is C_OUT_BIT_NUM+C_IN_BIT_NUM-1 bits wide. Fill count cnt ranges 0..C_OUT_BIT_NUM+C_IN_BIT_NUM-1.
- Accept: the sample is appended at bit position cnt (LSB order), or shifted in from the top (MSB order). cnt += C_IN_BIT_NUM.
- move = (cnt ≥ C_OUT_BIT_NUM) && (!o_valid || i_ready). On move:
  - The oldest C_OUT_BIT_NUM bits load the o0 register and o_valid is set.
  - acc shifts down by one word and cnt -= C_OUT_BIT_NUM.
- Move and accept may occur in the same cycle: cnt_next = cnt − C_OUT_BIT_NUM·move + C_IN_BIT_NUM·accept.
- o_ready = (cnt < C_OUT_BIT_NUM || move) && state==RUN && rst_n.
  - This is a combinational path from i_ready to o_ready; the path is documented and accepted.
- o_valid clears when i_ready is high and no new move occurs.
- While o_valid=1 && i_ready=0, o0 must stay stable.
- Output bit order within a sample is preserved: sample MSB is higher than sample LSB in either order.
- States:
  - RUN: normal packing.
  - FLUSH: entered when a sample with i_last=1 is accepted. Inputs are blocked (o_ready=0).
    - Full words are drained first.
    - If cnt>0 and cnt<C_OUT_BIT_NUM, the residue is emitted as one word, zero-padded in the unused positions (upper bits for LSB order, lower bits for MSB order).
    - The last emitted word has o_last=1. If cnt reaches exactly 0 after a full word, that word carries o_last.
    - Return to RUN once cnt=0 and the o_last word has been moved to the output register.

## Timing
- Reset values: o0=0, o_valid=0, o_last=0, o_ready=0 while rst_n=0, cnt=0, state=RUN. o_ready=1 on the first cycle after release.
- Latency: the word completed by an accepted sample is valid on o0 the cycle after the sample is accepted.
- Throughput: one sample per cycle sustained when i_ready=1; one word per cycle max.
- Back-pressure: with i_ready=0 and o_valid=1, o_ready stays high until cnt ≥ C_OUT_BIT_NUM, then drops.
- Reset asserted mid-frame discards acc, any pending word and FLUSH state. No partial word is emitted.
- i_valid dropping mid-word just holds cnt. No timeout flush.

## Configuration
- SAMPLE_PACKER_LAST_EN defined: i_last and o_last ports exist, and the FLUSH state and zero-padded residue word are implemented.
- Not defined: no i_last/o_last ports and no FLUSH state. Residue bits stay in acc until later samples complete the word.

## Structure
- Shared package:
  - bit-order constants "LSB"/"MSB";
  - an accumulator-width function (C_OUT_BIT_NUM+C_IN_BIT_NUM-1);
  - a clog2-based count-width constant;
  - state encoding RUN/FLUSH.
- Single flat module; no sub-module is warranted. Accumulator, counter and FSM fit in one file.

## Test plan
- 10→32, LSB order, samples 0x3FF, 0x001, 0x2AA, 0x155, i_ready=1 -> first word 0x6AA007FF; cnt=8 with residue 0x55.
- Same stimulus, last flag on 0x155 (macro on) -> second word 0x00000055 with o_last=1. o_ready=0 during FLUSH, then 1.
- 16 consecutive 0x3FF samples, 10→32, i_ready=1 -> exactly 5 words of 0xFFFFFFFF, o_ready never low, cnt=0 at end.
- i_ready held 0 for 10 cycles while streaming -> o0 stable, o_ready drops when cnt ≥ 32, no sample lost. Release yields the correct word sequence.
- 8→32 MSB order, samples 0x11, 0x22, 0x33, 0x44 -> word 0x11223344. Same samples in LSB order -> 0x44332211.
- rst_n pulsed low mid-frame with cnt=20 -> o_valid=0, o0=0, o_ready=0 during reset. Next 4 samples 0x3FF,0x001,0x2AA,0x155 reproduce 0x6AA007FF.
